// File: rtl/lane_select_counter_pkg.sv
// Shared types and helpers for the lane_select_counter block.
// Contents:
//   lane_sel_mode_t  - per-channel lane selection mode (IDX, PRI, MATCH, HOLD)
//   MAX_CW           - widest counter the helper functions handle
//   lowest_set_idx() - index of lowest set bit, all-ones lane index when zero
//   wildcard_hit()   - masked compare of a counter value against one entry
package lane_sel_pkg;

    typedef enum logic [1:0] {
        IDX   = 2'd0,
        PRI   = 2'd1,
        MATCH = 2'd2,
        HOLD  = 2'd3
    } lane_sel_mode_t;

    localparam int MAX_CW = 16;

    // Only the low cw bits of v are examined. A zero value maps to the
    // top lane (2**cw - 1) so every lane remains reachable in PRI mode.
    function automatic int lowest_set_idx(input logic [MAX_CW-1:0] v, input int cw);
        int idx;
        idx = (32'sd1 <<< cw) - 32'sd1;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = MAX_CW - 1; i >= 0; i--) begin
            if ((i < cw) && v[i]) begin
                idx = i;
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    function automatic logic wildcard_hit(input logic [MAX_CW-1:0] cnt,
                                          input logic [MAX_CW-1:0] val,
                                          input logic [MAX_CW-1:0] care);
        return (((cnt ^ val) & care) == {MAX_CW{1'b0}});
    endfunction

endpackage

// File: rtl/lane_select_counter_if.sv
// Bus bundle between the lane_select_counter and its driver.
// Signals:
//   wide_input_bus - LANES lanes of LANE_W bits, lane k at [k*LANE_W +: LANE_W]
//   cnt_en, decrement, dual_count, load - per-channel counter controls
//   load_val       - per-channel CW-bit load value
//   mode           - per-channel 2-bit lane_sel_mode_t
//   cnt_reg        - per-channel counter state (from design)
//   selected_out   - per-channel registered selected lane (from design)
// Modports: master drives controls and bus, slave is the design side.
interface lane_select_counter_if #(
    parameter int LANES    = 16,
    parameter int LANE_W   = 8,
    parameter int CHANNELS = 2
);
    localparam int CW = $clog2(LANES);

    logic [LANES*LANE_W-1:0]    wide_input_bus;
    logic [CHANNELS-1:0]        cnt_en;
    logic [CHANNELS-1:0]        decrement;
    logic [CHANNELS-1:0]        dual_count;
    logic [CHANNELS-1:0]        load;
    logic [CHANNELS*CW-1:0]     load_val;
    logic [CHANNELS*2-1:0]      mode;
    logic [CHANNELS*CW-1:0]     cnt_reg;
    logic [CHANNELS*LANE_W-1:0] selected_out;

    modport master (
        output wide_input_bus, cnt_en, decrement, dual_count, load, load_val, mode,
        input  cnt_reg, selected_out
    );

    modport slave (
        input  wide_input_bus, cnt_en, decrement, dual_count, load, load_val, mode,
        output cnt_reg, selected_out
    );

endinterface

// File: rtl/lane_select_counter_step.sv
// lane_step_counter: one channel's CW-bit up/down step counter.
// Priority: load, then count by 1 or 2 (up or down), else hold.
// Default build wraps modulo 2**CW; with LANE_SEL_SATURATE_EN defined the
// count clamps at 0 and 2**CW-1 instead (loads are never clamped).
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   load_i       - load load_val_i this edge
//   load_val_i   - CW-bit load value
//   en_i         - count enable
//   dec_i        - 1 = count down
//   dual_i       - 1 = step of 2
//   cnt_o        - registered counter value
module lane_step_counter #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    input  logic          en_i,
    input  logic          dec_i,
    input  logic          dual_i,
    output logic [CW-1:0] cnt_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] up_res_s;
    logic [CW-1:0] dn_res_s;

`ifdef LANE_SEL_SATURATE_EN
    // One extra bit exposes overflow and borrow for clamping.
    logic [CW:0] step_s;
    logic [CW:0] up_s;
    logic [CW:0] dn_s;

    // Saturating up/down candidates.
    always_comb begin
        step_s   = dual_i ? (CW+1)'(2) : (CW+1)'(1);
        up_s     = {1'b0, cnt_q} + step_s;
        dn_s     = {1'b0, cnt_q} - step_s;
        up_res_s = up_s[CW] ? {CW{1'b1}} : up_s[CW-1:0];
        dn_res_s = dn_s[CW] ? {CW{1'b0}} : dn_s[CW-1:0];
    end
`else
    logic [CW-1:0] step_s;

    // Wrapping up/down candidates; CW-bit arithmetic gives the modulo.
    always_comb begin
        step_s   = dual_i ? CW'(2) : CW'(1);
        up_res_s = cnt_q + step_s;
        dn_res_s = cnt_q - step_s;
    end
`endif

    // Next-state selection: load beats count beats hold.
    always_comb begin
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i) begin
            cnt_d = dec_i ? dn_res_s : up_res_s;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/lane_select_counter.sv
// lane_select_counter: CHANNELS independent step counters, each steering a
// registered byte-lane multiplexer over the shared wide input bus.
// Per-channel lane selection from the current counter value:
//   IDX   - lane = counter
//   PRI   - lane = lowest set bit of counter (LANES-1 when counter is 0)
//   MATCH - lane 0 if any wildcard entry matches, otherwise lane = counter
//   HOLD  - selected output keeps its value while the counter still runs
// Optional build macro LANE_SEL_SATURATE_EN: counters saturate instead of wrap.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset (clears counters and outputs)
//   bus  - lane_select_counter_if slave modport (controls, data, results)
module lane_select_counter
    import lane_sel_pkg::*;
#(
    parameter int LANES    = 16,
    parameter int LANE_W   = 8,
    parameter int CHANNELS = 2,
    parameter int NMATCH   = 2,
    parameter logic [NMATCH*$clog2(LANES)-1:0] MATCH_VAL  = {4'b1100, 4'b0000},
    parameter logic [NMATCH*$clog2(LANES)-1:0] MATCH_CARE = {4'b1111, 4'b0110}
) (
    input logic                  clk,
    input logic                  rst,
    lane_select_counter_if.slave bus
);

    localparam int CW = $clog2(LANES);

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        logic [CW-1:0]     cnt_s;
        lane_sel_mode_t    mode_s;
        logic              hit_s;
        logic [CW-1:0]     lane_s;
        logic [LANE_W-1:0] sel_d;
        logic [LANE_W-1:0] sel_q;

        lane_step_counter #(.CW(CW)) u_cnt (
            .clk        (clk),
            .rst        (rst),
            .load_i     (bus.load[ch]),
            .load_val_i (bus.load_val[ch*CW +: CW]),
            .en_i       (bus.cnt_en[ch]),
            .dec_i      (bus.decrement[ch]),
            .dual_i     (bus.dual_count[ch]),
            .cnt_o      (cnt_s)
        );

        assign mode_s = lane_sel_mode_t'(bus.mode[ch*2 +: 2]);

        // Lane index from the pre-edge counter value and the channel mode.
        always_comb begin
            hit_s = 1'b0;
            for (int i = 0; i < NMATCH; i++) begin
                hit_s = hit_s | wildcard_hit(MAX_CW'(cnt_s),
                                             MAX_CW'(MATCH_VAL[i*CW +: CW]),
                                             MAX_CW'(MATCH_CARE[i*CW +: CW]));
            end
            case (mode_s)
                IDX:     lane_s = cnt_s;
                PRI:     lane_s = CW'(lowest_set_idx(MAX_CW'(cnt_s), CW));
                MATCH:   lane_s = hit_s ? {CW{1'b0}} : cnt_s;
                HOLD:    lane_s = cnt_s;
                default: lane_s = cnt_s;
            endcase
        end

        // Lane data mux; HOLD recirculates the current output.
        always_comb begin
            if (mode_s == HOLD) begin
                sel_d = sel_q;
            end else begin
                sel_d = bus.wide_input_bus[int'(lane_s)*LANE_W +: LANE_W];
            end
        end

        // Selected-lane output register with synchronous reset.
        always_ff @(posedge clk) begin
            if (rst) begin
                sel_q <= {LANE_W{1'b0}};
            end else begin
                sel_q <= sel_d;
            end
        end

        assign bus.cnt_reg[ch*CW +: CW]          = cnt_s;
        assign bus.selected_out[ch*LANE_W +: LANE_W] = sel_q;
    end

endmodule

// File: tb/tb_lane_select_counter.sv
// Directed, scoreboard-checked bench for lane_select_counter (2 channels,
// 16 lanes of 8 bits). Stimulus pushes the expected post-edge state into a
// queue; a negedge monitor pops and compares. Expected values follow the
// build: define LANE_SEL_SATURATE_EN for the saturating variant.
module tb_lane_select_counter;
    import lane_sel_pkg::*;

`ifdef LANE_SEL_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        logic [3:0] c0;
        logic [7:0] s0;
        logic [3:0] c1;
        logic [7:0] s1;
        logic [3:0] m;     // [0]=c0 [1]=s0 [2]=c1 [3]=s1 compared
        string      name;
    } exp_t;

    logic clk;
    logic rst;
    logic [1:0] en_v, dec_v, dual_v, ld_v;
    logic [3:0] lv0, lv1;
    logic [1:0] md0, md1;

    exp_t sb_q[$];
    exp_t e;
    int   checks;
    int   failures;

    logic [7:0] lane_tbl [16] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7,
                                  8'h85, 8'h95, 8'hA5, 8'hB5, 8'hC5, 8'hD5, 8'hEF, 8'hF5};
    logic [3:0] match_ld [7]  = '{4'd0, 4'd1, 4'd8, 4'd9, 4'd12, 4'd10, 4'd4};
    logic [7:0] match_exp [7] = '{8'hA0, 8'hA0, 8'hA0, 8'hA0, 8'hA0, 8'hA0, 8'hA5};

    lane_select_counter_if #(.LANES(16), .LANE_W(8), .CHANNELS(2)) bus ();

    lane_select_counter #(
        .LANES(16), .LANE_W(8), .CHANNELS(2), .NMATCH(2),
        .MATCH_VAL({4'b1100, 4'b0000}), .MATCH_CARE({4'b1111, 4'b0110})
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    for (genvar k = 0; k < 16; k++) begin : g_bus
        assign bus.wide_input_bus[k*8 +: 8] = lane_tbl[k];
    end
    assign bus.cnt_en     = en_v;
    assign bus.decrement  = dec_v;
    assign bus.dual_count = dual_v;
    assign bus.load       = ld_v;
    assign bus.load_val   = {lv1, lv0};
    assign bus.mode       = {md1, md0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Monitor: compare every queued expectation against the settled outputs.
    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.m[0]) chk({e.name, ".cnt0"}, {4'h0, bus.cnt_reg[3:0]},  {4'h0, e.c0});
            if (e.m[1]) chk({e.name, ".sel0"}, bus.selected_out[7:0],     e.s0);
            if (e.m[2]) chk({e.name, ".cnt1"}, {4'h0, bus.cnt_reg[7:4]},  {4'h0, e.c1});
            if (e.m[3]) chk({e.name, ".sel1"}, bus.selected_out[15:8],    e.s1);
        end
    end

    // One clock edge; inputs were set at the preceding negedge.
    task automatic tick(input string nm, input logic [3:0] m,
                        input logic [3:0] c0, input logic [7:0] s0,
                        input logic [3:0] c1, input logic [7:0] s1);
        exp_t x;
        @(posedge clk);
        x.c0 = c0; x.s0 = s0; x.c1 = c1; x.s1 = s1; x.m = m; x.name = nm;
        sb_q.push_back(x);
        @(negedge clk);
    endtask

    initial begin
        int c, p, hold0;
        logic [3:0] prev1;
        checks = 0; failures = 0;
        rst = 1'b1;
        en_v = 2'b00; dec_v = 2'b00; dual_v = 2'b00; ld_v = 2'b00;
        lv0 = 4'd0; lv1 = 4'd0; md0 = 2'd0; md1 = 2'd0;
        @(negedge clk);

        // Reset state.
        tick("reset_a", 4'hF, 4'd0, 8'h00, 4'd0, 8'h00);
        tick("reset_b", 4'hF, 4'd0, 8'h00, 4'd0, 8'h00);
        rst = 1'b0;

        // ch0 IDX, count up by 1 across the wrap; ch1 idle on lane 0.
        en_v[0] = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            c = SAT ? ((k > 15) ? 15 : k) : (k % 16);
            p = SAT ? ((k - 1 > 15) ? 15 : k - 1) : ((k - 1) % 16);
            tick("idx_up", 4'hF, 4'(c), lane_tbl[p], 4'd0, 8'hA0);
        end
        en_v[0] = 1'b0;
        hold0 = SAT ? 15 : 1;

        // ch1 IDX, dual decrement from 0; ch0 holds independently.
        en_v[1] = 1'b1; dec_v[1] = 1'b1; dual_v[1] = 1'b1;
        prev1 = 4'd0;
        for (int j = 1; j <= 3; j++) begin
            c = SAT ? 0 : 16 - 2 * j;
            tick("dual_dn", 4'hF, 4'(hold0), lane_tbl[hold0], 4'(c), lane_tbl[prev1]);
            prev1 = 4'(c);
        end
        en_v[1] = 1'b0; dec_v[1] = 1'b0; dual_v[1] = 1'b0;
        tick("dual_dn_out", 4'hC, 4'd0, 8'h00, prev1, SAT ? 8'hA0 : 8'hA5);

        // PRI mode on ch0.
        md0 = 2'd1; ld_v[0] = 1'b1;
        lv0 = 4'd6; tick("pri_ld6", 4'h1, 4'd6, 8'h00, 4'd0, 8'h00);
        lv0 = 4'd8; tick("pri_6",   4'h3, 4'd8, 8'hA1, 4'd0, 8'h00);
        lv0 = 4'd0; tick("pri_8",   4'h3, 4'd0, 8'hA3, 4'd0, 8'h00);
        ld_v[0] = 1'b0;
        tick("pri_0", 4'h3, 4'd0, 8'hF5, 4'd0, 8'h00);

        // MATCH mode on ch0: each edge shows the verdict on the previous load.
        md0 = 2'd2; ld_v[0] = 1'b1;
        for (int j = 0; j < 7; j++) begin
            lv0 = match_ld[j];
            tick("match", 4'h3, match_ld[j], match_exp[j], 4'd0, 8'h00);
        end
        ld_v[0] = 1'b0;
        tick("match_4", 4'h3, 4'd4, 8'hA4, 4'd0, 8'h00);

        // HOLD: output frozen while the counter keeps counting.
        md0 = 2'd3; en_v[0] = 1'b1;
        tick("hold_a", 4'h3, 4'd5, 8'hA4, 4'd0, 8'h00);
        tick("hold_b", 4'h3, 4'd6, 8'hA4, 4'd0, 8'h00);

        // Load wins over count enable in the same cycle.
        md0 = 2'd0; ld_v[0] = 1'b1; lv0 = 4'd5;
        tick("load_wins", 4'h3, 4'd5, 8'hA6, 4'd0, 8'h00);
        ld_v[0] = 1'b0;

        // Mid-run reset, then counting resumes on the next edge.
        rst = 1'b1;
        tick("mid_rst", 4'hF, 4'd0, 8'h00, 4'd0, 8'h00);
        rst = 1'b0;
        tick("post_rst", 4'hF, 4'd1, 8'hA0, 4'd0, 8'hA0);
        en_v[0] = 1'b0;

        // Wrap versus saturate corner cases on ch1.
        ld_v[1] = 1'b1; lv1 = 4'd15;
        tick("ld15", 4'h4, 4'd0, 8'h00, 4'd15, 8'h00);
        ld_v[1] = 1'b0; en_v[1] = 1'b1;
        tick("up_15", 4'h4, 4'd0, 8'h00, SAT ? 4'd15 : 4'd0, 8'h00);
        en_v[1] = 1'b0; ld_v[1] = 1'b1; lv1 = 4'd14;
        tick("ld14", 4'h4, 4'd0, 8'h00, 4'd14, 8'h00);
        ld_v[1] = 1'b0; en_v[1] = 1'b1; dual_v[1] = 1'b1;
        tick("dual_up_14", 4'h4, 4'd0, 8'h00, SAT ? 4'd15 : 4'd0, 8'h00);
        en_v[1] = 1'b0; ld_v[1] = 1'b1; lv1 = 4'd1;
        tick("ld1", 4'h4, 4'd0, 8'h00, 4'd1, 8'h00);
        ld_v[1] = 1'b0; en_v[1] = 1'b1; dec_v[1] = 1'b1;
        tick("dual_dn_1", 4'h4, 4'd0, 8'h00, SAT ? 4'd0 : 4'd15, 8'h00);
        en_v[1] = 1'b0; dec_v[1] = 1'b0; dual_v[1] = 1'b0;

        // Drain: every pushed expectation must have been consumed.
        repeat (3) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain actual=%0d expected=0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
